demux_l1x4: RTL and testbench
=============================

# demux_l1x4

Receive-side de-interleaver of the PHY lane path. It accepts the single serialized byte stream produced by the transmit mux tree (one byte per `clk_4f` cycle, four lane slots per frame) and rebuilds the four parallel 8-bit lanes with per-lane valid flags. Everything runs in the `clk_4f` domain. It presents a new, fully populated 4-lane frame every four cycles, with a one-cycle frame strobe.

## Interface
- `DATA_W`, 8, lane byte width
- `clk_4f`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `sync`  in  1  frame alignment: the byte sampled this cycle is slot 0
- `data_in`  in  DATA_W  serialized lane byte
- `valid_in`  in  1  `data_in` holds valid data for the current slot
- `data_0..data_3`  out  DATA_W  recovered lane bytes, registered
- `valid_0..valid_3`  out  1  recovered lane valids, registered
- `frame_valid`  out  1  one-cycle strobe when the lane outputs carry a newly loaded frame

## Operation
- Slot counter `slot[1:0]` increments every cycle (0→1→2→3→0), independent of `valid_in`. The transmitter emits a slot every cycle; `valid_in`=0 only marks that lane idle.
- Slot-to-lane map (matches the 2-level TX interleave): slot0→lane0, slot1→lane2, slot2→lane1, slot3→lane3.
- Slots 0–2: sample `{valid_in, data_in}` into a staging register for the mapped lane.
- Slot 3: on the same edge, load all four output lanes from staging (lanes 0, 2, 1) and the live input (lane 3). Set `frame_valid`=1 for the following cycle.
- Lane data rule: if the lane's valid is 0, its output data is 0, regardless of `data_in`.
- Outputs hold between frame loads. `frame_valid`=0 except in the cycle after a slot-3 edge.
- `sync`=1 means the current byte is captured as slot 0 and the counter goes to 1 next. Staging for lanes 2, 1 and 3 is cleared to invalid, so a partial frame never mixes old and new alignment.
- `sync` asserted while already at slot 0 has no effect beyond normal operation.

## Timing
- Reset (`reset`=1 at an edge) sets:
  - slot counter = 0
  - all staging registers = invalid/0
  - all `data_*` = 0, all `valid_*` = 0, `frame_valid` = 0
- The first byte after reset release is slot 0.
- `reset` has priority over `sync`.
- Reset mid-frame discards the partial frame. No strobe is produced for it.
- Latency from capture edge to output visibility:
  - slot0 byte: visible after the slot-3 edge, i.e. 3 cycles after its capture edge
  - slot1 byte: 2 cycles
  - slot2 byte: 1 cycle
  - slot3 byte: visible right after its own capture edge
- Frame throughput: exactly one frame per 4 cycles in steady state.
- `sync` at slot 3 overrides the slot-3 load: no frame is loaded and no strobe is produced that cycle.

## Structure
- Shared package `phy_lane_pkg`:
  - `SLOT_W`=2
  - slot encoding constants `SLOT_L0`=0, `SLOT_L2`=1, `SLOT_L1`=2, `SLOT_L3`=3
  - lane count `N_LANES`=4
- The TX mux tree reuses the same package for its ordering.
- One natural sub-module: `lane_slot_ctr`. It is the 2-bit slot counter with `reset`/`sync` and a `slot_last` decode.
- Staging/output registers are implemented in the top module.

## Test plan
- Reset behaviour: hold `reset` for 3 cycles with random `data_in`. Expect all outputs 0 and `frame_valid`=0 throughout. After release, the first slot is 0.
- Basic frame: send bytes A1, B2, C3, D4 with `valid_in`=1 in slots 0–3. Expect `data_0`=A1, `data_2`=B2, `data_1`=C3, `data_3`=D4, all valids 1, and `frame_valid`=1 for exactly one cycle after the D4 edge.
- Idle lane: same frame with `valid_in`=0 in slot 2, data FF. Expect `valid_1`=0, `data_1`=00, and the other lanes correct.
- Sync mid-frame: assert `sync` at slot 2 with byte 55. Expect no strobe at the old slot-3 boundary. 55 appears on `data_0` after 3 more cycles, and lanes 2/1/3 take only the new bytes.
- Reset mid-frame: assert `reset` at slot 2. Expect outputs to return to 0 with no `frame_valid`. The next frame after release decodes correctly.
- Streaming: 16 back-to-back frames of incrementing bytes. Expect `frame_valid` every 4th cycle, each lane carrying its own incrementing sequence, with no drops and no stalls.

Source files
------------

// File: rtl/phy_lane_pkg.sv
// Shared lane-path definitions: slot encoding and lane ordering used by the TX mux
// tree and the RX de-interleaver.
package phy_lane_pkg;

    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned N_LANES = 4;
    localparam int unsigned LANE_W  = 2;

    localparam logic [SLOT_W-1:0] SLOT_L0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_L2 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_L1 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_L3 = 2'd3;

    // Two-level interleave order: slots 1 and 2 carry lanes 2 and 1.
    function automatic logic [LANE_W-1:0] slot_to_lane(input logic [SLOT_W-1:0] slot);
        logic [LANE_W-1:0] lane;
        unique case (slot)
            SLOT_L0: lane = 2'd0;
            SLOT_L2: lane = 2'd2;
            SLOT_L1: lane = 2'd1;
            SLOT_L3: lane = 2'd3;
            default: lane = 2'd0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/lane_slot_ctr.sv
// Free-running 2-bit lane slot counter with realignment on sync and a last-slot decode.
module lane_slot_ctr
    import phy_lane_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sync_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              slot_last_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;

    // A sync byte is slot 0 by definition, so the slot that follows it is always 1.
    always_comb begin
        slot_d = slot_q + SLOT_W'(1);
        if (sync_i) begin
            slot_d = SLOT_L0 + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q <= SLOT_L0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o      = slot_q;
    assign slot_last_o = (slot_q == SLOT_L3) && !sync_i;

endmodule

// File: rtl/demux_l1x4.sv
// RX lane de-interleaver: rebuilds four parallel lanes from the serialized slot stream
// and presents one complete frame every four cycles with a single-cycle strobe.
module demux_l1x4
    import phy_lane_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              sync,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic              valid_0,
    output logic              valid_1,
    output logic              valid_2,
    output logic              valid_3,
    output logic              frame_valid
);

    localparam int unsigned N_STG = N_LANES - 1;

    logic [SLOT_W-1:0] slot;
    logic              slot_last;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] stg_data_q [N_STG];
    logic [DATA_W-1:0] stg_data_d [N_STG];
    logic [N_STG-1:0]  stg_valid_q, stg_valid_d;

    logic [DATA_W-1:0]  out_data_q [N_LANES];
    logic [DATA_W-1:0]  out_data_d [N_LANES];
    logic [N_LANES-1:0] out_valid_q, out_valid_d;
    logic               frame_valid_q, frame_valid_d;

    lane_slot_ctr u_slot_ctr (
        .clk_i       (clk_4f),
        .reset_i     (reset),
        .sync_i      (sync),
        .slot_o      (slot),
        .slot_last_o (slot_last)
    );

    assign lane    = slot_to_lane(slot);
    assign in_data = valid_in ? data_in : '0;

    always_comb begin
        stg_data_d    = stg_data_q;
        stg_valid_d   = stg_valid_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_valid_d = 1'b0;

        if (sync) begin
            // Realign: drop any partial frame so old and new alignment never mix.
            for (int i = 0; i < int'(N_STG); i++) begin
                stg_data_d[i] = '0;
            end
            stg_valid_d    = '0;
            stg_data_d[0]  = in_data;
            stg_valid_d[0] = valid_in;
        end else if (slot_last) begin
            for (int i = 0; i < int'(N_STG); i++) begin
                out_data_d[i]  = stg_data_q[i];
                out_valid_d[i] = stg_valid_q[i];
            end
            out_data_d[N_LANES-1]  = in_data;
            out_valid_d[N_LANES-1] = valid_in;
            frame_valid_d          = 1'b1;
        end else begin
            stg_data_d[lane]  = in_data;
            stg_valid_d[lane] = valid_in;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < int'(N_STG); i++) begin
                stg_data_q[i] <= '0;
            end
            for (int i = 0; i < int'(N_LANES); i++) begin
                out_data_q[i] <= '0;
            end
            stg_valid_q   <= '0;
            out_valid_q   <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            stg_data_q    <= stg_data_d;
            stg_valid_q   <= stg_valid_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign data_0      = out_data_q[0];
    assign data_1      = out_data_q[1];
    assign data_2      = out_data_q[2];
    assign data_3      = out_data_q[3];
    assign valid_0     = out_valid_q[0];
    assign valid_1     = out_valid_q[1];
    assign valid_2     = out_valid_q[2];
    assign valid_3     = out_valid_q[3];
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_demux_l1x4.sv
// Self-checking bench for demux_l1x4: fixed vector table, directed corner sequences and
// random traffic against a frame-assembly reference model.
module tb_demux_l1x4;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic       sync;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       frame_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_4f = ~clk_4f;

    demux_l1x4 #(.DATA_W(8)) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .sync        (sync),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_0      (data_0),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .valid_2     (valid_2),
        .valid_3     (valid_3),
        .frame_valid (frame_valid)
    );

    // Reference model: bytes collected since alignment; the 4th completes a frame.
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } item_t;

    item_t      rx_q[$];
    logic [7:0] m_d [4];
    logic [3:0] m_v;
    logic       m_fv;
    int         lane_of_pos [4] = '{0, 2, 1, 3};

    function automatic logic [36:0] mk(input logic fv, input logic [3:0] v,
                                       input logic [31:0] d);
        return {fv, v, d};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {frame_valid, valid_3, valid_2, valid_1, valid_0,
                data_3, data_2, data_1, data_0};
    endfunction

    function automatic logic [36:0] model_vec();
        return {m_fv, m_v, m_d[3], m_d[2], m_d[1], m_d[0]};
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic v,
                              input logic [7:0] d);
        item_t it;
        if (r) begin
            rx_q.delete();
            for (int i = 0; i < 4; i++) m_d[i] = 8'h00;
            m_v  = 4'h0;
            m_fv = 1'b0;
            return;
        end
        it.v = v;
        it.d = v ? d : 8'h00;
        if (s) rx_q.delete();
        rx_q.push_back(it);
        m_fv = 1'b0;
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                m_d[lane_of_pos[i]] = rx_q[i].d;
                m_v[lane_of_pos[i]] = rx_q[i].v;
            end
            m_fv = 1'b1;
            rx_q.delete();
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic v, input logic [7:0] d);
        reset    = r;
        sync     = s;
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        #1;
        model_edge(r, s, v, d);
    endtask

    task automatic check(input string name, input logic [36:0] exp);
        logic [36:0] act;
        act = dut_vec();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got fv=%b v=%b d=%h, expected fv=%b v=%b d=%h",
                     name, act[36], act[35:32], act[31:0], exp[36], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d,
                        input string name);
        tick(r, s, v, d);
        check(name, model_vec());
    endtask

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic [36:0] exp;
    } vec_t;

    vec_t tbl[9];
    int   strobes;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'hA1, mk(1'b0, 4'h0, 32'h0000_0000)};
        tbl[1] = '{1'b0, 1'b1, 8'hB2, mk(1'b0, 4'h0, 32'h0000_0000)};
        tbl[2] = '{1'b0, 1'b1, 8'hC3, mk(1'b0, 4'h0, 32'h0000_0000)};
        tbl[3] = '{1'b0, 1'b1, 8'hD4, mk(1'b1, 4'hF, 32'hD4B2_C3A1)};
        tbl[4] = '{1'b0, 1'b1, 8'h11, mk(1'b0, 4'hF, 32'hD4B2_C3A1)};
        tbl[5] = '{1'b0, 1'b1, 8'h22, mk(1'b0, 4'hF, 32'hD4B2_C3A1)};
        tbl[6] = '{1'b0, 1'b0, 8'hFF, mk(1'b0, 4'hF, 32'hD4B2_C3A1)};
        tbl[7] = '{1'b0, 1'b1, 8'h44, mk(1'b1, 4'b1101, 32'h4422_0011)};
        tbl[8] = '{1'b0, 1'b0, 8'h00, mk(1'b0, 4'b1101, 32'h4422_0011)};

        // Reset held for three cycles with random data.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'($urandom), 8'($urandom));
            check("reset_hold", mk(1'b0, 4'h0, 32'h0));
        end

        // Basic frame then idle-lane frame; first byte after release is slot 0.
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, tbl[i].s, tbl[i].v, tbl[i].d);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Sync mid-frame at slot 2.
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h10, "sync_pre0");
        step(1'b0, 1'b0, 1'b1, 8'h20, "sync_pre1");
        step(1'b0, 1'b1, 1'b1, 8'h55, "sync_edge");
        step(1'b0, 1'b0, 1'b1, 8'h66, "sync_old_boundary");
        check("sync_no_strobe", mk(1'b0, 4'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 8'h77, "sync_s2");
        step(1'b0, 1'b0, 1'b1, 8'h88, "sync_s3");
        check("sync_frame", mk(1'b1, 4'hF, 32'h8866_7755));

        // Streaming: 16 back-to-back frames of incrementing bytes.
        strobes = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, (i == 0), 1'b1, 8'(i), "stream");
            if (frame_valid) strobes++;
        end
        vectors++;
        if (strobes != 16) begin
            miscompares++;
            $display("FAIL stream_strobes: got %0d, expected 16", strobes);
        end

        // Reset mid-frame at slot 2, then a clean frame.
        step(1'b0, 1'b0, 1'b1, 8'hE1, "rstmid_s0");
        step(1'b0, 1'b0, 1'b1, 8'hE2, "rstmid_s1");
        tick(1'b1, 1'b0, 1'b1, 8'hE3);
        check("rstmid_clear", mk(1'b0, 4'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 8'h01, "rstmid_f0");
        step(1'b0, 1'b0, 1'b1, 8'h02, "rstmid_f1");
        step(1'b0, 1'b0, 1'b1, 8'h03, "rstmid_f2");
        check("rstmid_nostrobe", mk(1'b0, 4'h0, 32'h0));
        step(1'b0, 1'b0, 1'b1, 8'h04, "rstmid_f3");
        check("rstmid_frame", mk(1'b1, 4'hF, 32'h0402_0301));

        // Random traffic with occasional sync and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), 8'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
